// File: rtl/cpu_pkg.sv
// Shared definitions for the risc-me control path: opcodes, sequencer states,
// datapath mux encodings and the decoded-opcode bundle.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_FETCH_MEM,
    ST_DECODE,
    ST_EXEC_ADDR,
    ST_EXEC_MEM,
    ST_EXEC_ALU,
    ST_HALT
  } ctrl_state_t;

  localparam logic MAR_SEL_PC  = 1'b0;
  localparam logic MAR_SEL_OP  = 1'b1;
  localparam logic ACC_SEL_MEM = 1'b0;
  localparam logic ACC_SEL_ALU = 1'b1;

  typedef struct packed {
    logic needs_mem;
    logic is_store;
    logic is_alu;
    logic is_jump;
    logic is_halt;
    logic is_illegal;
  } ctrl_dec_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Sequencer <-> datapath/memory bundle. master = sequencer, slave = datapath.
interface ctrl_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_latch;
  logic             pc_inc;
  logic             ir_latch;
  logic             mar_latch;
  logic             mar_sel;
  logic             acc_latch;
  logic             acc_sel;
  logic             alu_sub;
  logic             mem_rd;
  logic             mem_wr;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_latch, pc_inc, ir_latch, mar_latch, mar_sel, acc_latch, acc_sel,
           alu_sub, mem_rd, mem_wr, halted, illegal, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_latch, pc_inc, ir_latch, mar_latch, mar_sel, acc_latch, acc_sel,
           alu_sub, mem_rd, mem_wr, halted, illegal, retired
  );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode classifier used by the sequencer FSM.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_dec_t  o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_NOP: ;
      OP_LDA: o_dec.needs_mem = 1'b1;
      OP_STA: begin
        o_dec.needs_mem = 1'b1;
        o_dec.is_store  = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        o_dec.needs_mem = 1'b1;
        o_dec.is_alu    = 1'b1;
      end
      OP_JMP, OP_JZ: o_dec.is_jump = 1'b1;
      OP_HLT:        o_dec.is_halt = 1'b1;
      default:       o_dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the risc-me datapath.
// FETCH:mar<-pc | FETCH_MEM:read IR | DECODE:classify | EXEC_ADDR:mar<-op
// EXEC_MEM:operand rd/wr | EXEC_ALU:acc<-acc+/-mem | HALT:parked until reset
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_AW = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               reset_n,
  ctrl_sequencer_if.master  bus
);

  if (MEM_AW < 1 || MEM_AW > 4) begin : g_aw_check
    $error("MEM_AW must fit inside the 4-bit operand field");
  end

  ctrl_state_t      r_state;
  logic [CNT_W-1:0] r_retired;
  ctrl_dec_t        w_dec;

  ctrl_decode u_decode (
    .i_opcode (bus.opcode),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_FETCH;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_FETCH:     r_state <= ST_FETCH_MEM;
        ST_FETCH_MEM: if (bus.mem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_dec.is_halt) begin
            r_state   <= ST_HALT;
            r_retired <= r_retired + CNT_W'(1);
          end else if (w_dec.needs_mem) begin
            r_state <= ST_EXEC_ADDR;
          end else begin
            r_state   <= ST_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        ST_EXEC_ADDR: r_state <= ST_EXEC_MEM;
        ST_EXEC_MEM: begin
          if (bus.mem_ready) begin
            if (w_dec.is_alu) begin
              r_state <= ST_EXEC_ALU;
            end else begin
              r_state   <= ST_FETCH;
              r_retired <= r_retired + CNT_W'(1);
            end
          end
        end
        ST_EXEC_ALU: begin
          r_state   <= ST_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        ST_HALT: ;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Strobes are masked while reset is held so a reset mid-request drops it at once.
  always_comb begin
    bus.pc_latch  = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.ir_latch  = 1'b0;
    bus.mar_latch = 1'b0;
    bus.mar_sel   = MAR_SEL_PC;
    bus.acc_latch = 1'b0;
    bus.acc_sel   = ACC_SEL_MEM;
    bus.alu_sub   = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.halted    = 1'b0;
    bus.illegal   = 1'b0;
    if (reset_n) begin
      case (r_state)
        ST_FETCH: begin
          bus.mar_latch = 1'b1;
          bus.mar_sel   = MAR_SEL_PC;
        end
        ST_FETCH_MEM: begin
          bus.mem_rd   = 1'b1;
          bus.ir_latch = bus.mem_ready;
          bus.pc_inc   = bus.mem_ready;
        end
        ST_DECODE: begin
          bus.illegal  = w_dec.is_illegal;
          bus.pc_latch = w_dec.is_jump && ((bus.opcode != OP_JZ) || bus.zero);
        end
        ST_EXEC_ADDR: begin
          bus.mar_latch = 1'b1;
          bus.mar_sel   = MAR_SEL_OP;
        end
        ST_EXEC_MEM: begin
          bus.mem_wr = w_dec.is_store;
          bus.mem_rd = !w_dec.is_store;
          if (bus.mem_ready && !w_dec.is_store && !w_dec.is_alu) begin
            bus.acc_latch = 1'b1;
            bus.acc_sel   = ACC_SEL_MEM;
          end
        end
        ST_EXEC_ALU: begin
          bus.acc_latch = 1'b1;
          bus.acc_sel   = ACC_SEL_ALU;
          bus.alu_sub   = (bus.opcode == OP_SUB);
        end
        ST_HALT: bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.retired = r_retired;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle strobe vectors and retire count.
module tb_ctrl_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [7:0] exp_ret;

  ctrl_sequencer_if #(.CNT_W(8)) bus ();

  ctrl_sequencer #(.MEM_AW(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Bit order: mar_latch mar_sel mem_rd mem_wr | ir_latch pc_inc pc_latch acc_latch | acc_sel alu_sub halted illegal
  localparam logic [11:0] V_NONE     = 12'b0000_0000_0000;
  localparam logic [11:0] V_FETCH    = 12'b1000_0000_0000;
  localparam logic [11:0] V_FMEM_RDY = 12'b0010_1100_0000;
  localparam logic [11:0] V_FMEM_WT  = 12'b0010_0000_0000;
  localparam logic [11:0] V_EADDR    = 12'b1100_0000_0000;
  localparam logic [11:0] V_ERD      = 12'b0010_0000_0000;
  localparam logic [11:0] V_ELDA     = 12'b0010_0001_0000;
  localparam logic [11:0] V_EWR      = 12'b0001_0000_0000;
  localparam logic [11:0] V_ALU_ADD  = 12'b0000_0001_1000;
  localparam logic [11:0] V_ALU_SUB  = 12'b0000_0001_1100;
  localparam logic [11:0] V_JUMP     = 12'b0000_0010_0000;
  localparam logic [11:0] V_ILL      = 12'b0000_0000_0001;
  localparam logic [11:0] V_HALT     = 12'b0000_0000_0010;

  function automatic logic [11:0] strobes();
    return {bus.mar_latch, bus.mar_sel, bus.mem_rd, bus.mem_wr,
            bus.ir_latch, bus.pc_inc, bus.pc_latch, bus.acc_latch,
            bus.acc_sel, bus.alu_sub, bus.halted, bus.illegal};
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (strobes() !== V_NONE) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected %b", strobes(), V_NONE);
    end
    checks++;
    if (bus.retired !== 8'd0) begin
      errors++;
      $display("FAIL reset_retired: got %0d expected 0", bus.retired);
    end
    reset_n = 1'b1;
    exp_ret = 8'd0;
  endtask

  task automatic test_nop();
    logic [11:0] ev [3] = '{V_FETCH, V_FMEM_RDY, V_NONE};
    bus.opcode = 4'h0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (strobes() !== ev[i]) begin
        errors++;
        $display("FAIL nop_c%0d: got %b expected %b", i + 1, strobes(), ev[i]);
      end
      if (i == 2) begin
        checks++;
        if (bus.retired !== exp_ret) begin
          errors++;
          $display("FAIL nop_retired_early: got %0d expected %0d", bus.retired, exp_ret);
        end
      end
      next_cycle();
    end
    exp_ret++;
    checks++;
    if (bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL nop_retired: got %0d expected %0d", bus.retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] ev [3] = '{V_FETCH, V_FMEM_WT, V_FMEM_WT};
    bus.opcode = 4'h1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (strobes() !== ev[i]) begin
        errors++;
        $display("FAIL rstmid_c%0d: got %b expected %b", i + 1, strobes(), ev[i]);
      end
      if (i < 2) next_cycle();
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (strobes() !== V_NONE) begin
      errors++;
      $display("FAIL rstmid_drop: got %b expected %b", strobes(), V_NONE);
    end
    checks++;
    if (bus.retired !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_retired: got %0d expected 0", bus.retired);
    end
    exp_ret = 8'd0;
    next_cycle();
    checks++;
    if (strobes() !== V_NONE) begin
      errors++;
      $display("FAIL rstmid_held: got %b expected %b", strobes(), V_NONE);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (strobes() !== V_FETCH) begin
      errors++;
      $display("FAIL rstmid_first_fetch: got %b expected %b", strobes(), V_FETCH);
    end
  endtask

  task automatic test_add_stall();
    logic [11:0] ev  [8] = '{V_FETCH, V_FMEM_RDY, V_NONE, V_EADDR, V_ERD, V_ERD, V_ERD, V_ALU_ADD};
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = 4'h3;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (strobes() !== ev[i]) begin
        errors++;
        $display("FAIL add_c%0d: got %b expected %b", i + 1, strobes(), ev[i]);
      end
      if (i == 7) begin
        checks++;
        if (bus.retired !== exp_ret) begin
          errors++;
          $display("FAIL add_retired_early: got %0d expected %0d", bus.retired, exp_ret);
        end
      end
      next_cycle();
    end
    exp_ret++;
    checks++;
    if (bus.retired !== exp_ret || strobes() !== V_FETCH) begin
      errors++;
      $display("FAIL add_done: retired %0d strobes %b expected %0d %b", bus.retired, strobes(), exp_ret, V_FETCH);
    end
  endtask

  task automatic test_mem_ops();
    logic [11:0] ev_sub [6] = '{V_FETCH, V_FMEM_RDY, V_NONE, V_EADDR, V_ERD, V_ALU_SUB};
    logic [11:0] ev_lda [5] = '{V_FETCH, V_FMEM_RDY, V_NONE, V_EADDR, V_ELDA};
    logic [11:0] ev_sta [6] = '{V_FETCH, V_FMEM_RDY, V_NONE, V_EADDR, V_EWR, V_EWR};
    logic        rdy_sta [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.opcode = 4'h4;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (strobes() !== ev_sub[i]) begin
        errors++;
        $display("FAIL sub_c%0d: got %b expected %b", i + 1, strobes(), ev_sub[i]);
      end
      next_cycle();
    end
    exp_ret++;
    bus.opcode = 4'h1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (strobes() !== ev_lda[i]) begin
        errors++;
        $display("FAIL lda_c%0d: got %b expected %b", i + 1, strobes(), ev_lda[i]);
      end
      next_cycle();
    end
    exp_ret++;
    bus.opcode = 4'h2;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rdy_sta[i];
      #1;
      checks++;
      if (strobes() !== ev_sta[i]) begin
        errors++;
        $display("FAIL sta_c%0d: got %b expected %b", i + 1, strobes(), ev_sta[i]);
      end
      next_cycle();
    end
    exp_ret++;
    checks++;
    if (bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL memops_retired: got %0d expected %0d", bus.retired, exp_ret);
    end
  endtask

  task automatic test_jumps();
    logic [3:0]  ops [3] = '{4'h6, 4'h6, 4'h5};
    logic        zs  [3] = '{1'b0, 1'b1, 1'b0};
    logic [11:0] dv  [3] = '{V_NONE, V_JUMP, V_JUMP};
    logic [11:0] ev;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.opcode = ops[k];
      bus.zero   = zs[k];
      for (int i = 0; i < 3; i++) begin
        ev = (i == 0) ? V_FETCH : (i == 1) ? V_FMEM_RDY : dv[k];
        #1;
        checks++;
        if (strobes() !== ev) begin
          errors++;
          $display("FAIL jump%0d_c%0d: got %b expected %b", k, i + 1, strobes(), ev);
        end
        next_cycle();
      end
      exp_ret++;
      checks++;
      if (bus.retired !== exp_ret) begin
        errors++;
        $display("FAIL jump%0d_retired: got %0d expected %0d", k, bus.retired, exp_ret);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [11:0] ev [4] = '{V_FETCH, V_FMEM_RDY, V_ILL, V_FETCH};
    bus.opcode = 4'hC;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (strobes() !== ev[i]) begin
        errors++;
        $display("FAIL illegal_c%0d: got %b expected %b", i + 1, strobes(), ev[i]);
      end
      if (i == 2) exp_ret++;
      if (i < 3) next_cycle();
    end
    checks++;
    if (bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL illegal_retired: got %0d expected %0d", bus.retired, exp_ret);
    end
  endtask

  task automatic test_halt();
    logic [11:0] ev [3] = '{V_FETCH, V_FMEM_RDY, V_NONE};
    bus.opcode = 4'h7;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (strobes() !== ev[i]) begin
        errors++;
        $display("FAIL halt_c%0d: got %b expected %b", i + 1, strobes(), ev[i]);
      end
      next_cycle();
    end
    exp_ret++;
    for (int i = 0; i < 21; i++) begin
      bus.mem_ready = i[0];
      bus.opcode = (i > 10) ? 4'h1 : 4'h7;
      #1;
      checks++;
      if (strobes() !== V_HALT || bus.retired !== exp_ret) begin
        errors++;
        $display("FAIL halt_hold%0d: strobes %b retired %0d expected %b %0d", i, strobes(), bus.retired, V_HALT, exp_ret);
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    exp_ret = 8'd0;
    bus.opcode = 4'h0;
    bus.mem_ready = 1'b1;
    repeat (765) @(negedge clk);
    #1;
    exp_ret = 8'd255;
    checks++;
    if (bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL wrap_preload: got %0d expected %0d", bus.retired, exp_ret);
    end
    repeat (3) next_cycle();
    exp_ret++;
    checks++;
    if (bus.retired !== exp_ret || strobes() !== V_FETCH) begin
      errors++;
      $display("FAIL wrap_zero: retired %0d strobes %b expected %0d %b", bus.retired, strobes(), exp_ret, V_FETCH);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    checks = 0;
    errors = 0;
    exp_ret = 8'd0;
    bus.opcode = 4'h0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_nop();
    test_reset_mid();
    test_add_stall();
    test_mem_ops();
    test_jumps();
    test_illegal();
    test_halt();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control sequencer for the 8-bit risc-me datapath. It drives the latch/inc strobes of the PC, IR, MAR and accumulator `register` instances, and the memory read/write handshake. It sequences fetch, decode and execute for a 4-bit-opcode / 4-bit-operand instruction word, and keeps a count of retired instructions.

## Interface
Parameters:
- `MEM_AW`, default 4: memory address width; the operand is `ir[MEM_AW-1:0]`.
- `CNT_W`, default 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  4: `ir[7:4]`, valid from the cycle after `ir_latch`.
- `zero`  in  1: accumulator-equals-zero flag from the datapath.
- `mem_ready`  in  1: memory completed the current read or write.
- `pc_latch` / `pc_inc`  out  1: PC load from operand / PC increment.
- `ir_latch`  out  1: IR load from memory data.
- `mar_latch`  out  1: MAR load.
- `mar_sel`  out  1: MAR source; 0 = PC, 1 = IR operand.
- `acc_latch`  out  1: accumulator load.
- `acc_sel`  out  1: accumulator source; 0 = memory data, 1 = ALU.
- `alu_sub`  out  1: ALU operation; 0 = add, 1 = subtract.
- `mem_rd` / `mem_wr`  out  1: memory request, held until `mem_ready`.
- `halted`  out  1: the sequencer is in HALT.
- `illegal`  out  1: one-cycle pulse on decode of an undefined opcode.
- `retired`  out  CNT_W: count of completed instructions.

## Operation
Opcodes:
- 0 NOP
- 1 LDA: acc ← mem[op]
- 2 STA: mem[op] ← acc
- 3 ADD: acc ← acc + mem[op]
- 4 SUB: acc ← acc − mem[op]
- 5 JMP: pc ← op
- 6 JZ: pc ← op if `zero`
- 7 HLT
- 8–15: illegal, executed as NOP with an `illegal` pulse.

States and transitions:
- **FETCH**: `mar_latch=1`, `mar_sel=0` → FETCH_MEM.
- **FETCH_MEM**: `mem_rd=1`. Stay here while `mem_ready=0`. On `mem_ready=1`, assert `ir_latch=1` and `pc_inc=1` in that same cycle (Mealy outputs) → DECODE.
- **DECODE**:
  - NOP or illegal → FETCH.
  - LDA, STA, ADD, SUB → EXEC_ADDR.
  - JMP → FETCH with `pc_latch=1`.
  - JZ → FETCH with `pc_latch=zero`.
  - HLT → HALT.
- **EXEC_ADDR**: `mar_latch=1`, `mar_sel=1` → EXEC_MEM.
- **EXEC_MEM**:
  - Assert `mem_wr` for STA and `mem_rd` otherwise, until `mem_ready`.
  - On `mem_ready`: LDA asserts `acc_latch=1`, `acc_sel=0`, then → FETCH; ADD/SUB → EXEC_ALU; STA → FETCH.
- **EXEC_ALU**: `acc_latch=1`, `acc_sel=1`, `alu_sub=(op==SUB)` → FETCH.
- **HALT**: `halted=1`, all strobes 0. Only reset exits this state.

Retirement:
- `retired` increments by 1 on every transition into FETCH from DECODE, EXEC_MEM or EXEC_ALU, and on the transition into HALT.
- It wraps from 2^CNT_W−1 to 0.

Outputs not listed for a state are 0. `mem_rd` and `mem_wr` are never both 1.

## Timing
- Reset: on `reset_n` falling, the state becomes FETCH immediately (asynchronously), every strobe, `halted` and `illegal` go to 0, and `retired` goes to 0. Reset is legal in any state, including mid-memory-request. The request drops the same cycle.
- The first FETCH strobe is asserted in the first cycle after `reset_n` rises.
- Cycle counts with `mem_ready` tied high:
  - NOP, JMP, JZ, HLT, illegal: 3 cycles.
  - LDA, STA: 5 cycles.
  - ADD, SUB: 6 cycles.
  - Each cycle of `mem_ready=0` adds one cycle.
- `mem_ready` is sampled only in FETCH_MEM and EXEC_MEM and is ignored elsewhere.
- `opcode` is sampled in DECODE and EXEC_MEM, and in EXEC_ALU to drive `alu_sub`. It must be stable from DECODE until the next FETCH.
- `illegal` is high for exactly the DECODE cycle.
- `state` and `retired` are registered. Strobes are combinational from `state`, `opcode`, `zero` and `mem_ready`.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams `OP_NOP`…`OP_HLT`;
  - the state enum typedef `ctrl_state_t`;
  - `MAR_SEL_PC` / `MAR_SEL_OP` and `ACC_SEL_MEM` / `ACC_SEL_ALU`.
- One combinational sub-module, `ctrl_decode`: opcode → {needs_mem, is_store, is_alu, is_jump, is_halt, is_illegal}.
- The FSM, strobe logic and counter stay in `ctrl_sequencer`.

## Test plan
- Reset mid-FETCH_MEM with `mem_ready=0` → `mem_rd` drops the same cycle and `retired=0`. After release, `mar_latch=1`, `mar_sel=0` in the first cycle.
- NOP, `mem_ready` high → strobe sequence FETCH/FETCH_MEM/DECODE over 3 cycles, `ir_latch` and `pc_inc` together in cycle 2, `retired=1`.
- ADD (0x3A) with `mem_ready` low for 2 extra cycles in EXEC_MEM → `mem_rd` high for 3 cycles, then `acc_latch=1`, `acc_sel=1`, `alu_sub=0`, for 8 cycles in total.
- JZ (0x65) with `zero=0`, then with `zero=1` → `pc_latch` stays 0 in the first case and pulses once in DECODE in the second.
- Opcode 0xC0 → `illegal` pulses for 1 cycle and `retired` increments. HLT (0x70) → `halted=1` and stays high for 20 further cycles, with `retired` unchanged.
- Preload with 255 retired instructions, then run one NOP → `retired` wraps to 0.
